bcd_seg_scan_2digit: RTL and testbench



---
 rtl/bcd_seg_scan_2digit.sv | 164 ++++++++++++++++
 tb/tb_bcd_seg_scan_2digit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_scan_2digit.sv
// bcd_seg_scan_2digit
// Drives a multiplexed two-digit seven-segment display from a 5-bit BCD word
// (tens bit plus ones digit). A four-state scan cycle lights the ones digit, goes
// dark for a gap, lights the tens digit, and goes dark for a second gap. The shown
// value is latched only at the frame boundary, so a frame never mixes two values.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   bcd         bcd[4] = tens digit (0/1), bcd[3:0] = ones digit
//   valid       bcd is meaningful this cycle; captured into the pending word
//   blank_lead  1 = tens digit dark when it is 0 (sampled live)
//   seg         segment drive, seg[0]=a .. seg[6]=g, polarity per ACTIVE_LOW
//   dig_sel     digit enable, [0]=ones, [1]=tens, polarity per ACTIVE_LOW
//   frame_start one-cycle pulse on the edge that enters the ones slot
module bcd_seg_scan_2digit #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned GAP_CYC    = 4,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] bcd,
  input  logic       valid,
  input  logic       blank_lead,
  output logic [6:0] seg,
  output logic [1:0] dig_sel,
  output logic       frame_start
);

  localparam int unsigned MaxLen = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
  localparam int unsigned CntW   = (MaxLen > 1) ? $clog2(MaxLen) : 1;

  localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYC - 1);

  localparam logic [6:0] SegOff = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [1:0] DigOff = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

  typedef enum logic [1:0] {
    StOnes,
    StGapA,
    StTens,
    StGapB
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      pend_q, pend_d;
  logic            pend_ok_q, pend_ok_d;
  logic [4:0]      disp_q, disp_d;
  logic            disp_ok_q, disp_ok_d;
  logic [6:0]      seg_q, seg_d;
  logic [1:0]      dig_sel_q, dig_sel_d;
  logic            frame_start_q, frame_start_d;

  logic [CntW-1:0] cnt_last;
  logic            at_last;
  logic            boundary;
  logic [6:0]      glyph;
  logic [1:0]      dig_on;

  // Active-high glyphs, bit order g..a; non-decimal codes show a dash.
  function automatic logic [6:0] ones_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = 7'h40;
    endcase
    return g;
  endfunction

  always_comb begin
    cnt_last = ((state_q == StOnes) || (state_q == StTens)) ? ScanLast : GapLast;
    at_last  = (cnt_q == cnt_last);
    boundary = at_last && (state_q == StGapB);

    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    if (at_last) begin
      cnt_d = '0;
      case (state_q)
        StOnes:  state_d = StGapA;
        StGapA:  state_d = StTens;
        StTens:  state_d = StGapB;
        default: state_d = StOnes;
      endcase
    end

    pend_d    = valid ? bcd : pend_q;
    pend_ok_d = valid | pend_ok_q;

    // The boundary takes the pending word as it stood before this edge, so a
    // coincident valid lands in pend only and is shown one frame later.
    disp_d    = boundary ? pend_q : disp_q;
    disp_ok_d = boundary ? pend_ok_q : disp_ok_q;

    // Outputs follow the next state so they switch on the same edge as the FSM.
    glyph  = 7'h00;
    dig_on = 2'b00;
    if (disp_ok_d) begin
      case (state_d)
        StOnes: begin
          glyph  = ones_glyph(disp_d[3:0]);
          dig_on = 2'b01;
        end
        StTens: begin
          dig_on = 2'b10;
          if (disp_d[4]) begin
            glyph = 7'h06;
          end else if (!blank_lead) begin
            glyph = 7'h3F;
          end
        end
        default: begin
          glyph  = 7'h00;
          dig_on = 2'b00;
        end
      endcase
    end

    seg_d         = (ACTIVE_LOW != 0) ? ~glyph : glyph;
    dig_sel_d     = (ACTIVE_LOW != 0) ? ~dig_on : dig_on;
    frame_start_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StGapB;
      cnt_q         <= '0;
      pend_q        <= '0;
      pend_ok_q     <= 1'b0;
      disp_q        <= '0;
      disp_ok_q     <= 1'b0;
      seg_q         <= SegOff;
      dig_sel_q     <= DigOff;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      pend_ok_q     <= pend_ok_d;
      disp_q        <= disp_d;
      disp_ok_q     <= disp_ok_d;
      seg_q         <= seg_d;
      dig_sel_q     <= dig_sel_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dig_sel     = dig_sel_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bcd_seg_scan_2digit.sv
// Self-checking bench for bcd_seg_scan_2digit (SCAN_DIV=4, GAP_CYC=1, active-low).
// A frame-position model (edge count modulo the frame period) predicts every
// output cycle; a vector table and hand sequences add fixed-value checks.
module tb_bcd_seg_scan_2digit;

  localparam int S = 4;
  localparam int G = 1;
  localparam int F = 2 * S + 2 * G;

  logic       clk;
  logic       rst_n;
  logic [4:0] bcd;
  logic       valid;
  logic       blank_lead;
  logic [6:0] seg;
  logic [1:0] dig_sel;
  logic       frame_start;

  bcd_seg_scan_2digit #(
    .SCAN_DIV  (S),
    .GAP_CYC   (G),
    .ACTIVE_LOW(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd        (bcd),
    .valid      (valid),
    .blank_lead (blank_lead),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .frame_start(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int npass  = 0;
  int ntotal = 0;

  // Reference model state
  int         k;
  int         m_p;
  logic [4:0] m_pend, m_disp;
  bit         m_pend_ok, m_disp_ok;
  logic [6:0] e_seg;
  logic [1:0] e_dig;
  logic       e_fs;

  logic [6:0] glyph_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  typedef struct {
    logic [4:0] vbcd;
    logic       vblank;
    logic [6:0] exp_ones;
    logic [6:0] exp_tens;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h (edge %0d, pos %0d)", name, act, exp, k, m_p);
  endtask

  task automatic model_reset();
    k         = 0;
    m_p       = F - 1;
    m_pend    = '0;
    m_disp    = '0;
    m_pend_ok = 0;
    m_disp_ok = 0;
    e_seg     = 7'h7F;
    e_dig     = 2'b11;
    e_fs      = 1'b0;
  endtask

  task automatic model_step();
    k++;
    m_p = (k - 1) % F;
    if (m_p == 0) begin
      m_disp    = m_pend;
      m_disp_ok = m_pend_ok;
    end
    if (valid) begin
      m_pend    = bcd;
      m_pend_ok = 1;
    end
    e_fs  = (m_p == 0);
    e_seg = 7'h7F;
    e_dig = 2'b11;
    if (m_disp_ok) begin
      if (m_p < S) begin
        e_dig = 2'b10;
        e_seg = ~glyph_tab[m_disp[3:0]];
      end else if (m_p >= S + G && m_p < 2 * S + G) begin
        e_dig = 2'b01;
        e_seg = m_disp[4] ? ~7'h06 : (blank_lead ? 7'h7F : ~7'h3F);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model seg", {1'b0, seg}, {1'b0, e_seg});
    chk("model dig_sel", {6'b0, dig_sel}, {6'b0, e_dig});
    chk("model frame_start", {7'b0, frame_start}, {7'b0, e_fs});
  endtask

  task automatic pulse(input logic [4:0] v);
    bcd   = v;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  // Advance to the next cycle at frame position target (at most one frame).
  task automatic wait_pos(input int target);
    for (int i = 0; i < F; i++) begin
      tick();
      if (m_p == target) break;
    end
  endtask

  initial begin
    int fs_count;

    vecs[0] = '{5'b1_0101, 1'b0, 7'h12, 7'h79};
    vecs[1] = '{5'b0_0111, 1'b1, 7'h78, 7'h7F};
    vecs[2] = '{5'b0_0111, 1'b0, 7'h78, 7'h40};
    vecs[3] = '{5'b0_1100, 1'b0, 7'h3F, 7'h40};
    vecs[4] = '{5'b0_0000, 1'b1, 7'h40, 7'h7F};
    vecs[5] = '{5'b1_1001, 1'b1, 7'h10, 7'h79};
    vecs[6] = '{5'b0_0011, 1'b0, 7'h30, 7'h40};
    vecs[7] = '{5'b1_1111, 1'b0, 7'h3F, 7'h79};
    vecs[8] = '{5'b0_1000, 1'b1, 7'h00, 7'h7F};

    rst_n      = 1'b0;
    bcd        = '0;
    valid      = 1'b0;
    blank_lead = 1'b0;
    model_reset();
    #8;
    chk("reset seg", {1'b0, seg}, 8'h7F);
    chk("reset dig_sel", {6'b0, dig_sel}, 8'h03);
    chk("reset frame_start", {7'b0, frame_start}, 8'h00);
    #4 rst_n = 1'b1;

    // No valid yet: dark for three frames, pulses every F cycles starting at once.
    fs_count = 0;
    for (int i = 0; i < 3 * F; i++) begin
      tick();
      if (i == 0) chk("first frame_start", {7'b0, frame_start}, 8'h01);
      if (frame_start) fs_count++;
    end
    chk("frame_start count", 8'(fs_count), 8'd3);

    // Vector table: valid pulsed mid-frame, shown in the following frame.
    wait_pos(2);
    foreach (vecs[i]) begin
      blank_lead = vecs[i].vblank;
      pulse(vecs[i].vbcd);
      wait_pos(0);
      chk("vec ones seg", {1'b0, seg}, {1'b0, vecs[i].exp_ones});
      chk("vec ones dig", {6'b0, dig_sel}, 8'h02);
      wait_pos(4);
      chk("vec gap seg", {1'b0, seg}, 8'h7F);
      chk("vec gap dig", {6'b0, dig_sel}, 8'h03);
      wait_pos(5);
      chk("vec tens seg", {1'b0, seg}, {1'b0, vecs[i].exp_tens});
      chk("vec tens dig", {6'b0, dig_sel}, 8'h01);
      wait_pos(9);
      chk("vec gapb seg", {1'b0, seg}, 8'h7F);
      wait_pos(5);
    end

    // blank_lead toggled live inside the tens slot.
    blank_lead = 1'b1;
    pulse(5'b0_0111);
    wait_pos(0);
    wait_pos(6);
    chk("blank tens dark", {1'b0, seg}, 8'h7F);
    blank_lead = 1'b0;
    tick();
    chk("blank released", {1'b0, seg}, 8'h40);

    // Three valids in one frame: last one wins.
    wait_pos(1);
    pulse(5'd3);
    pulse(5'd8);
    pulse(5'd9);
    wait_pos(0);
    chk("last valid wins", {1'b0, seg}, 8'h10);
    // Valid coincident with the boundary edge is deferred one frame.
    wait_pos(9);
    pulse(5'd2);
    chk("boundary fs", {7'b0, frame_start}, 8'h01);
    chk("boundary valid deferred", {1'b0, seg}, 8'h10);
    wait_pos(0);
    chk("deferred valid shown", {1'b0, seg}, 8'h24);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      valid      = ($urandom_range(0, 3) == 0);
      bcd        = 5'($urandom);
      blank_lead = 1'($urandom_range(0, 1));
      tick();
    end
    valid      = 1'b0;
    blank_lead = 1'b0;

    // Asynchronous reset in the middle of the tens slot.
    pulse(5'b1_0010);
    wait_pos(0);
    wait_pos(6);
    chk("pre-reset tens lit", {6'b0, dig_sel}, 8'h01);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset seg", {1'b0, seg}, 8'h7F);
    chk("async reset dig_sel", {6'b0, dig_sel}, 8'h03);
    chk("async reset frame_start", {7'b0, frame_start}, 8'h00);
    model_reset();
    #4 rst_n = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    chk("post-reset dark seg", {1'b0, seg}, 8'h7F);
    chk("post-reset dark dig", {6'b0, dig_sel}, 8'h03);
    wait_pos(2);
    pulse(5'b0_0001);
    wait_pos(0);
    chk("post-reset value", {1'b0, seg}, 8'h79);
    chk("post-reset ones dig", {6'b0, dig_sel}, 8'h02);
    for (int i = 0; i < F; i++) tick();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
